// File: rtl/fpga_bus_pkg.sv
// Shared types and constants for the MCU-side bus initiator of the ECC memory bridge.
package fpga_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } state_t;

  localparam int DATA_W = 16;
  localparam int FLAG_W = 3;

  localparam logic [1:0] CS_ACTIVE = 2'b00;
  localparam logic [1:0] CS_IDLE   = 2'b11;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Where each injection field sits inside the LFSR state
  localparam int RV13_LSB = 0;
  localparam int RV13_W   = 3;
  localparam int RV17_LSB = 3;
  localparam int RV17_W   = 7;
  localparam int POS_LSB  = 10;
  localparam int POS_W    = 5;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr_fault_gen.sv
// Free-running Galois LFSR; its state is sliced into fault-injection fields
// that are captured on a command accept and gated by the per-command inject bit.
module lfsr_fault_gen
  import fpga_bus_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic              inject,
  output logic [RV13_W-1:0] random_values13,
  output logic [RV17_W-1:0] random_values17,
  output logic [POS_W-1:0]  random_positions
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr             <= LFSR_SEED;
      random_values13  <= '0;
      random_values17  <= '0;
      random_positions <= '0;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (sample) begin
        random_values13  <= inject ? lfsr[RV13_LSB +: RV13_W] : '0;
        random_values17  <= inject ? lfsr[RV17_LSB +: RV17_W] : '0;
        random_positions <= inject ? lfsr[POS_LSB +: POS_W]   : '0;
      end
    end
  end

endmodule

// File: rtl/mcu_bus_master.sv
// Single-word bus initiator: sequences chip-select, strobes and the shared data
// bus through SETUP/STROBE/HOLD phases and returns a one-cycle response.
module mcu_bus_master
  import fpga_bus_pkg::*;
#(
  parameter int          SETUP_CYC  = 1,
  parameter int          STROBE_CYC = 2,
  parameter int          HOLD_CYC   = 1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [1:0]        cmd_ecc_sel,
  input  logic              cmd_inject,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [FLAG_W-1:0] rsp_flag,
  inout  wire  [DATA_W-1:0] bus_io,
  output logic              write_en,
  output logic              output_en,
  output logic [1:0]        chip_sel,
  output logic [1:0]        ecc_sel,
  output logic [2:0]        random_values13,
  output logic [6:0]        random_values17,
  output logic [4:0]        random_positions,
  input  logic [FLAG_W-1:0] flag_in
);

  state_t            state;
  logic [3:0]        cnt;
  logic              cmd_write_p0;
  logic [DATA_W-1:0] cmd_data_p0;
  logic              accept;

  assign accept = (state == ST_IDLE) && cmd_valid && cmd_ready;

  // Tying the drive enable to write_en itself makes contention with the bridge impossible
  assign bus_io = write_en ? {DATA_W{1'bz}} : cmd_data_p0;

  lfsr_fault_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_fault_gen (
    .clk              (clk),
    .rst              (rst),
    .sample           (accept),
    .inject           (cmd_inject),
    .random_values13  (random_values13),
    .random_values17  (random_values17),
    .random_positions (random_positions)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cmd_ready    <= 1'b1;
      write_en     <= 1'b1;
      output_en    <= 1'b1;
      chip_sel     <= CS_IDLE;
      ecc_sel      <= 2'b00;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_flag     <= '0;
      cmd_write_p0 <= 1'b0;
      cmd_data_p0  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_write_p0 <= cmd_write;
            cmd_data_p0  <= cmd_data;
            ecc_sel      <= cmd_ecc_sel;
            chip_sel     <= CS_ACTIVE;
            cmd_ready    <= 1'b0;
            cnt          <= 4'(SETUP_CYC - 1);
            state        <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            write_en  <= ~cmd_write_p0;
            output_en <= cmd_write_p0;
            cnt       <= 4'(STROBE_CYC - 1);
            state     <= ST_STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == 4'd0) begin
            // Sampling at the end of the last strobe cycle lets the bridge's registered flag settle
            if (!cmd_write_p0) begin
              rsp_data <= bus_io;
              rsp_flag <= flag_in;
            end
            write_en  <= 1'b1;
            output_en <= 1'b1;
            cnt       <= 4'(HOLD_CYC - 1);
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            if (cmd_write_p0) begin
              rsp_data <= cmd_data_p0;
              rsp_flag <= '0;
            end
            chip_sel  <= CS_IDLE;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_bus_master.sv
// Directed bench for mcu_bus_master: strobe timing, read capture, back-to-back
// commands, fault-field sampling, mid-transaction reset and a slow-timing instance.
module tb_mcu_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_valid2, cmd_write, cmd_inject;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_ecc_sel;

  logic        cmd_ready, rsp_valid, write_en, output_en;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_flag, flag_in, random_values13;
  logic [1:0]  chip_sel, ecc_sel;
  logic [6:0]  random_values17;
  logic [4:0]  random_positions;
  wire  [15:0] bus_io;

  logic        cmd_ready2, rsp_valid2, write_en2, output_en2;
  logic [15:0] rsp_data2;
  logic [2:0]  rsp_flag2, flag_in2, rv13_2;
  logic [1:0]  chip_sel2, ecc_sel2;
  logic [6:0]  rv17_2;
  logic [4:0]  rpos_2;
  wire  [15:0] bus2;

  logic [15:0] bdata, bdata2, m_lfsr, exp_l;
  logic [2:0]  bflag, bflag2;
  int          pass_cnt = 0, fail_cnt = 0, total_cnt = 0;
  int          contention = 0, contention2 = 0, seen;

  always #5 clk = ~clk;

  mcu_bus_master u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_data(cmd_data), .cmd_ecc_sel(cmd_ecc_sel),
    .cmd_inject(cmd_inject), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_flag(rsp_flag), .bus_io(bus_io), .write_en(write_en),
    .output_en(output_en), .chip_sel(chip_sel), .ecc_sel(ecc_sel),
    .random_values13(random_values13), .random_values17(random_values17),
    .random_positions(random_positions), .flag_in(flag_in)
  );

  mcu_bus_master #(.SETUP_CYC(3), .STROBE_CYC(4), .HOLD_CYC(2)) u_slow (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write), .cmd_data(cmd_data), .cmd_ecc_sel(cmd_ecc_sel),
    .cmd_inject(cmd_inject), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .rsp_flag(rsp_flag2), .bus_io(bus2), .write_en(write_en2),
    .output_en(output_en2), .chip_sel(chip_sel2), .ecc_sel(ecc_sel2),
    .random_values13(rv13_2), .random_values17(rv17_2),
    .random_positions(rpos_2), .flag_in(flag_in2)
  );

  // Bridge models: drive the bus unless in a write strobe, flag registered off output_en
  assign bus_io = write_en  ? bdata  : 16'hzzzz;
  assign bus2   = write_en2 ? bdata2 : 16'hzzzz;

  always @(posedge clk) begin
    flag_in  <= !output_en  ? bflag  : 3'b000;
    flag_in2 <= !output_en2 ? bflag2 : 3'b000;
  end

  always @(negedge clk) begin
    if (write_en && bus_io !== bdata) contention <= contention + 1;
    if (write_en2 && bus2 !== bdata2) contention2 <= contention2 + 1;
  end

  // Reference Galois LFSR, taps 0xB400, right shift
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    cmd_valid = 0; cmd_valid2 = 0; cmd_write = 0; cmd_data = 0;
    cmd_ecc_sel = 0; cmd_inject = 0;
    bdata = 0; bdata2 = 0; bflag = 0; bflag2 = 0;

    // Reset state
    repeat (2) step();
    chk("rst_we", 32'(write_en), 32'd1);
    chk("rst_oe", 32'(output_en), 32'd1);
    chk("rst_cs", 32'(chip_sel), 32'h3);
    chk("rst_ecc", 32'(ecc_sel), 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_data, rsp_flag}), 32'h0);
    chk("rst_fields", 32'({random_values13, random_values17, random_positions}), 32'h0);
    chk("rst_bus", 32'(bus_io), 32'h0);
    rst = 0;
    step();
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // Write A5C3, ecc 01, no injection
    cmd_write = 1; cmd_data = 16'hA5C3; cmd_ecc_sel = 2'b01; cmd_valid = 1;
    step();
    cmd_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      chk("wr_we", 32'(write_en), 32'((k == 2 || k == 3) ? 1'b0 : 1'b1));
      chk("wr_bus", 32'(bus_io), 32'((k == 2 || k == 3) ? 16'hA5C3 : 16'h0000));
      chk("wr_oe", 32'(output_en), 32'd1);
      chk("wr_cs", 32'(chip_sel), 32'((k <= 4) ? 2'b00 : 2'b11));
      chk("wr_vld", 32'(rsp_valid), 32'(k == 5));
      chk("wr_rdy", 32'(cmd_ready), 32'(k == 6));
      if (k == 5) begin
        chk("wr_data", 32'(rsp_data), 32'hA5C3);
        chk("wr_flag", 32'(rsp_flag), 32'h0);
        chk("wr_ecc", 32'(ecc_sel), 32'h1);
        chk("wr_fields", 32'({random_values13, random_values17, random_positions}), 32'h0);
      end
    end

    // Read: bridge returns 1234 with flag 010
    bdata = 16'h1234; bflag = 3'b010;
    cmd_write = 0; cmd_data = 16'hFFFF; cmd_ecc_sel = 2'b10; cmd_valid = 1;
    step();
    cmd_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      chk("rd_oe", 32'(output_en), 32'((k == 2 || k == 3) ? 1'b0 : 1'b1));
      chk("rd_we", 32'(write_en), 32'd1);
      chk("rd_vld", 32'(rsp_valid), 32'(k == 5));
      if (k == 5) begin
        chk("rd_data", 32'(rsp_data), 32'h1234);
        chk("rd_flag", 32'(rsp_flag), 32'h2);
        chk("rd_ecc", 32'(ecc_sel), 32'h2);
      end
    end
    bdata = 16'h0000; bflag = 3'b000;

    // Back-to-back writes with cmd_valid held
    cmd_write = 1; cmd_data = 16'h0F0F; cmd_valid = 1;
    step();
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) step();
      chk("b2b_rdy", 32'(cmd_ready), 32'(k == 6 || k == 12));
      chk("b2b_cs", 32'(chip_sel), 32'((((k - 1) % 6) < 4) ? 2'b00 : 2'b11));
      chk("b2b_vld", 32'(rsp_valid), 32'(k == 5 || k == 11));
      if (k == 7) cmd_valid = 0;
    end

    // Injection after a fresh reset
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    exp_l = m_lfsr;
    cmd_inject = 1; cmd_write = 1; cmd_data = 16'h1111; cmd_valid = 1;
    step();
    cmd_valid = 0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      chk("inj_rv13", 32'(random_values13), 32'(exp_l[2:0]));
      chk("inj_rv17", 32'(random_values17), 32'(exp_l[9:3]));
      chk("inj_pos", 32'(random_positions), 32'(exp_l[14:10]));
    end
    step();
    cmd_inject = 0;

    // Reset during a write strobe
    cmd_write = 1; cmd_data = 16'hA5C3; cmd_ecc_sel = 2'b11; cmd_valid = 1;
    step();
    cmd_valid = 0;
    step();
    chk("mid_we_pre", 32'(write_en), 32'd0);
    chk("mid_bus_pre", 32'(bus_io), 32'hA5C3);
    #1 rst = 1;
    #1;
    chk("mid_we", 32'(write_en), 32'd1);
    chk("mid_cs", 32'(chip_sel), 32'h3);
    chk("mid_bus", 32'(bus_io), 32'h0);
    chk("mid_ecc", 32'(ecc_sel), 32'h0);
    step();
    rst = 0;
    seen = 0;
    repeat (8) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("mid_no_rsp", 32'(seen), 32'd0);
    chk("mid_ready", 32'(cmd_ready), 32'd1);

    // Slow instance read: 3/4/2 timing
    bdata2 = 16'hBEEF; bflag2 = 3'b101;
    cmd_write = 0; cmd_valid2 = 1;
    step();
    cmd_valid2 = 0;
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) step();
      chk("slow_vld", 32'(rsp_valid2), 32'(k == 10));
      chk("slow_oe", 32'(output_en2), 32'((k >= 4 && k <= 7) ? 1'b0 : 1'b1));
      chk("slow_cs", 32'(chip_sel2), 32'((k <= 9) ? 2'b00 : 2'b11));
      if (k == 10) begin
        chk("slow_data", 32'(rsp_data2), 32'hBEEF);
        chk("slow_flag", 32'(rsp_flag2), 32'h5);
      end
    end
    chk("slow_rdy", 32'(cmd_ready2), 32'd1);

    chk("contention", 32'(contention), 32'd0);
    chk("contention2", 32'(contention2), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
